// File: rtl/execute_skid_buf_pkg.sv
// execute_skid_buf_pkg: decoded-bundle layout and skid FSM encoding shared by the execute skid buffer.
package execute_skid_buf_pkg;
    localparam int INST_TYPE_W = 3;
    localparam int ALU_OP_W    = 5;
    localparam int LSU_OP_W    = 4;
    localparam int CSR_OP_W    = 3;
    localparam int WSEL_W      = 3;
    localparam int WENA_W      = 1;
    localparam int WADDR_W     = 5;
    localparam int CSR_WENA_W  = 1;
    localparam int CSR_WADDR_W = 12;
    localparam int PC_W        = 64;
    localparam int IMM_W       = 64;
    localparam int RDATA_W     = 64;
    localparam int CSR_RDATA_W = 64;
    // Bundle is packed MSB-first, so offsets build up from csr_rdata at bit 0.
    localparam int CSR_RDATA_LSB = 0;
    localparam int RDATA2_LSB    = CSR_RDATA_LSB + CSR_RDATA_W;
    localparam int RDATA1_LSB    = RDATA2_LSB + RDATA_W;
    localparam int IMM_LSB       = RDATA1_LSB + RDATA_W;
    localparam int PC_LSB        = IMM_LSB + IMM_W;
    localparam int CSR_WADDR_LSB = PC_LSB + PC_W;
    localparam int CSR_WENA_LSB  = CSR_WADDR_LSB + CSR_WADDR_W;
    localparam int WADDR_LSB     = CSR_WENA_LSB + CSR_WENA_W;
    localparam int WENA_LSB      = WADDR_LSB + WADDR_W;
    localparam int WSEL_LSB      = WENA_LSB + WENA_W;
    localparam int CSR_OP_LSB    = WSEL_LSB + WSEL_W;
    localparam int LSU_OP_LSB    = CSR_OP_LSB + CSR_OP_W;
    localparam int ALU_OP_LSB    = LSU_OP_LSB + LSU_OP_W;
    localparam int INST_TYPE_LSB = ALU_OP_LSB + ALU_OP_W;
    localparam int EXU_BUNDLE_W  = INST_TYPE_LSB + INST_TYPE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;
endpackage

// File: rtl/execute_payload_reg.sv
// execute_payload_reg: payload register with load enable and synchronous clear (clear wins).
module execute_payload_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock)
        q <= clear ? '0 : load ? d : q;
endmodule

// File: rtl/execute_skid_buf.sv
// execute_skid_buf: two-entry decode-to-execute skid buffer with registered in_ready/out_valid.
// Optional EXECUTE_SKID_FLUSH_EN adds flush_i to squash held bundles.
module execute_skid_buf
    import execute_skid_buf_pkg::*;
#(
    parameter int PAYLOAD_W = EXU_BUNDLE_W
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef EXECUTE_SKID_FLUSH_EN
    input  logic                 flush_i,
`endif
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 out_ready
);
    skid_state_e           state, state_nxt;
    logic                  in_fire, out_fire;
    logic                  out_load, skid_load, out_sel_skid;
    logic [PAYLOAD_W-1:0]  skid_q;

    assign out_valid = state != EMPTY;
    assign in_ready  = state != FULL;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clock)
        state <= reset ? EMPTY : state_nxt;

    always_comb begin
        state_nxt    = state;
        out_load     = 1'b0;
        skid_load    = 1'b0;
        out_sel_skid = 1'b0;
        case (state)
            EMPTY: begin
                out_load  = in_fire;
                state_nxt = in_fire ? BUSY : EMPTY;
            end
            BUSY: begin
                out_load  = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
                state_nxt = skid_load ? FULL : (out_fire & ~in_fire) ? EMPTY : BUSY;
            end
            FULL: begin
                out_load     = out_fire;
                out_sel_skid = 1'b1;
                state_nxt    = out_fire ? BUSY : FULL;
            end
            default: state_nxt = EMPTY;
        endcase
`ifdef EXECUTE_SKID_FLUSH_EN
        if (flush_i) begin
            state_nxt = EMPTY;
            out_load  = 1'b0;
            skid_load = 1'b0;
        end
`endif
    end

    execute_payload_reg #(.W(PAYLOAD_W)) u_out_reg (
        .clock (clock),
        .clear (reset),
        .load  (out_load),
        .d     (out_sel_skid ? skid_q : in_payload),
        .q     (out_payload)
    );

    execute_payload_reg #(.W(PAYLOAD_W)) u_skid_reg (
        .clock (clock),
        .clear (reset),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
    );
endmodule

// File: tb/tb_execute_skid_buf.sv
// tb_execute_skid_buf: directed and random scoreboard bench for execute_skid_buf.
module tb_execute_skid_buf;
    import execute_skid_buf_pkg::*;
    localparam int W = EXU_BUNDLE_W;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush_i = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_payload = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_payload;

    int           tests = 0, fails = 0, accepted = 0;
    logic [W-1:0] sb[$];
    logic         hold = 1'b0;
    logic [W-1:0] held = '0;

    execute_skid_buf dut (
        .clock       (clock),
        .reset       (reset),
`ifdef EXECUTE_SKID_FLUSH_EN
        .flush_i     (flush_i),
`endif
        .in_valid    (in_valid),
        .in_payload  (in_payload),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_payload (out_payload),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_payload();
        logic [W-1:0] p = '0;
        for (int i = 0; i < 12; i++) p = {p[W-33:0], 32'($urandom)};
        return p;
    endfunction

    // Monitor: captures accepted bundles, checks delivered ones and hold stability.
    always @(negedge clock) begin
        if (reset || flush_i) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_payload", out_payload, held);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: delivered %0h with nothing expected", out_payload);
                end else chk("scoreboard", out_payload, sb.pop_front());
            end
            hold = out_valid && !out_ready;
            held = out_payload;
            if (in_valid && in_ready) begin
                sb.push_back(in_payload);
                accepted++;
            end
        end
    end

    initial begin
        int cyc, start;
        step();
        step();
        reset = 1'b0;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_payload", out_payload, W'(0));

        in_valid = 1'b1; in_payload = W'(8'hA5); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_out_valid", W'(out_valid), W'(1));
        chk("lat_payload", out_payload, W'(8'hA5));
        chk("lat_in_ready", W'(in_ready), W'(1));
        step();
        chk("lat_drained", W'(out_valid), W'(0));

        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = W'(8'h11);
        step();
        in_payload = W'(8'h22);
        step();
        in_valid = 1'b0;
        chk("full_in_ready", W'(in_ready), W'(0));
        chk("full_out_valid", W'(out_valid), W'(1));
        chk("full_payload", out_payload, W'(8'h11));
        out_ready = 1'b1;
        step();
        chk("skid_second", out_payload, W'(8'h22));
        chk("skid_second_valid", W'(out_valid), W'(1));
        chk("skid_in_ready", W'(in_ready), W'(1));
        step();
        chk("skid_drained", W'(out_valid), W'(0));

        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_payload = W'(i);
            step();
            chk("stream_valid", W'(out_valid), W'(1));
            chk("stream_payload", out_payload, W'(i));
        end
        in_valid = 1'b0;
        step();

        start = accepted;
        cyc = 0;
        while (accepted < start + 10000 && cyc < 60000) begin
            in_valid = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
            in_payload = rnd_payload();
            step();
            cyc++;
        end
        if (cyc >= 60000) begin
            tests++;
            fails++;
            $display("FAIL random_timeout: accepted %0d of 10000", accepted - start);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", W'(sb.size()), W'(0));

        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = W'(8'h33);
        step();
        in_payload = W'(8'h44);
        step();
        chk("pre_reset_full", W'(in_ready), W'(0));
        reset = 1'b1; in_payload = W'(8'h77);
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_payload", out_payload, W'(0));
        out_ready = 1'b1;
        step();
        chk("midrst_stays_empty", W'(out_valid), W'(0));

`ifdef EXECUTE_SKID_FLUSH_EN
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = W'(8'h55);
        step();
        in_payload = W'(8'h66);
        step();
        flush_i = 1'b1; in_payload = W'(8'h99);
        step();
        flush_i = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_in_ready", W'(in_ready), W'(1));
        chk("flush_payload_kept", out_payload, W'(8'h55));
        out_ready = 1'b1;
        step();
        chk("flush_no_delivery", W'(out_valid), W'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/execute_skid_buf.md
EXECUTE_SKID_BUF -- requirements
Module: execute_skid_buf

Interface
REQ-001 Parameter: PAYLOAD_W, default EXU_BUNDLE_W from package, bit width of the decoded bundle (inst_type, alu_op, lsu_op, csr_op, wsel, wena, waddr, csr_wena, csr_waddr, pc, imm, rdata1, rdata2, csr_rdata, packed MSB-first in that order).
REQ-002 The clock SHALL be clock; the reset SHALL be reset, synchronous, active-high.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  decode offers a bundle.
REQ-006 in_payload  input  PAYLOAD_W  bundle from decode.
REQ-007 in_ready  output  1  buffer accepts a bundle this cycle; a registered output, so decode uses it as its write enable.
REQ-008 out_valid  output  1  bundle is available to execute.
REQ-009 out_payload  output  PAYLOAD_W  bundle to execute, registered.
REQ-010 out_ready  input  1  execute consumes this cycle.
REQ-011 flush_i  input  1  squash contents; present only with the macro in REQ-027.

Function
REQ-012 The block SHALL provide in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; a transfer occurs only on a fire.
REQ-013 The FSM SHALL have states EMPTY (0 entries), BUSY (1 entry in the output register) and FULL (output register plus skid register occupied).
REQ-014 The block SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only, with no combinational path from out_ready.
REQ-015 In EMPTY, in_fire SHALL load out_payload and move the FSM to BUSY; otherwise the FSM SHALL hold.
REQ-016 In BUSY with in_fire and no out_fire, the skid register SHALL be loaded and the FSM SHALL move to FULL.
REQ-017 In BUSY with out_fire and no in_fire, the FSM SHALL move to EMPTY.
REQ-018 In BUSY with both fires, out_payload SHALL load in_payload and the FSM SHALL stay in BUSY.
REQ-019 In FULL, out_fire SHALL copy skid into out_payload and move the FSM to BUSY; otherwise the FSM SHALL hold.
REQ-020 Latency: an input accepted in EMPTY SHALL appear on out_payload with out_valid=1 in the next cycle.
REQ-021 Sustained throughput with out_ready=1 SHALL be 1 bundle per cycle.
REQ-022 Ordering SHALL be strict FIFO, with no loss or duplication.
REQ-023 out_payload SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 in_payload SHALL be ignored when in_fire=0.

Reset
REQ-025 Reset SHALL set the FSM to EMPTY, out_valid=0, in_ready=1, and out_payload and skid to all zeros.
REQ-026 Reset asserted mid-operation SHALL discard all held bundles at that edge, with priority over every fire and over flush.

Configuration
REQ-027 Macro EXECUTE_SKID_FLUSH_EN, when defined, SHALL add port flush_i; flush_i=1 at an edge SHALL force the FSM to EMPTY, with priority over both fires (an in_fire in that cycle is dropped), and SHALL leave the payload registers unchanged.
REQ-028 When EXECUTE_SKID_FLUSH_EN is undefined, flush_i and all flush logic SHALL be absent, and behaviour SHALL be exactly REQ-012..REQ-026.

Structure
REQ-029 The shared package SHALL hold EXU_BUNDLE_W, the field widths and offsets of the packed bundle, and the state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2).
REQ-030 The payload registers SHALL be one sub-module, execute_payload_reg (a PAYLOAD_W-wide register with load enable and synchronous clear), instantiated twice (output register and skid register).
REQ-031 State 2'd3 SHALL be unreachable, and on entry SHALL recover to EMPTY.

Verification
REQ-032 Reset, then in_valid=1 with payload 0xA5 and out_ready=1 -> out_valid=1 and out_payload=0xA5 the next cycle; in_ready stays 1.
REQ-033 out_ready=0, push 0x11 then 0x22 -> FULL, in_ready=0; raise out_ready -> 0x11 then 0x22 delivered on consecutive cycles.
REQ-034 Stream 0x01..0x10 with in_valid=1, out_ready=1 -> 16 outputs in order on 16 consecutive cycles.
REQ-035 Random in_valid/out_ready at 50% for 10k bundles -> scoreboard matches exactly, and out_payload is stable whenever out_valid & !out_ready.
REQ-036 In FULL, assert reset -> next cycle out_valid=0, in_ready=1, out_payload=0.
REQ-037 With EXECUTE_SKID_FLUSH_EN, in FULL assert flush_i together with in_valid=1 -> next cycle EMPTY, out_valid=0, and the new bundle is not delivered.
